battleship_turn_fsm: RTL

- Parametrised game-flow controller for the Battleship VGA game; next generation of the game state machine.
- Sequences start, ship placement, alternating player/PC turns, win/loss detection and per-turn time limit.
- Sits between input debouncers/switch logic, the board/ship-count registers and the VGA renderer, which decodes its one-hot status outputs.
- Adds over the previous generation: configurable ship-count width, a turn timeout, a dedicated resolve cycle per shot, a turn counter and PC-turn handshake.

---
 rtl/battleship_turn_fsm.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/battleship_turn_fsm.sv
// Game-flow controller for Battleship: start, placing, alternating turns with a resolve cycle, win/loss, turn timeout.
// Latency: start/fire edge to next state 1 cycle after the edge register; pc_done to player_turn 2 cycles. No backpressure.
// Optional: BATTLESHIP_HIT_BONUS_EN grants an extra player shot after a hit.
module battleship_turn_fsm #(
    parameter int          SHIP_W      = 3,
    parameter logic [31:0] TURN_CYCLES = 32'd250_000_000,
    parameter int          TIMER_W     = 32,
    parameter int          TURN_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  finished_placing,
    input  logic                  player_fire,
    input  logic                  player_hit,
    input  logic                  pc_done,
    input  logic [SHIP_W-1:0]     player_ships,
    input  logic [SHIP_W-1:0]     pc_ships,
    output logic                  placing_ships,
    output logic                  player_turn,
    output logic                  pc_turn,
    output logic                  is_victory,
    output logic                  is_defeat,
    output logic                  pc_go,
    output logic                  timeout,
    output logic [TIMER_W-1:0]    time_left,
    output logic [TURN_CNT_W-1:0] turn_count
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PLACING     = 3'd1,
        PLAYER_TURN = 3'd2,
        P_RESOLVE   = 3'd3,
        PC_TURN     = 3'd4,
        C_RESOLVE   = 3'd5,
        VICTORY     = 3'd6,
        DEFEAT      = 3'd7
    } state_t;

    localparam bit TIMER_EN = (TURN_CYCLES != 32'd0);
    localparam logic [TIMER_W-1:0] TIME_LOAD =
        TIMER_EN ? TIMER_W'(TURN_CYCLES - 32'd1) : '0;

    state_t state_q, state_d;
    logic   start_q, start_qq, fire_q, fire_qq;
    logic   start_edge, fire_edge, expire;
    logic   pc_go_d, timeout_d;
    logic   enter_player, leave_player, restart;

    assign start_edge = start_q & ~start_qq;
    assign fire_edge  = fire_q & ~fire_qq;
    assign expire     = TIMER_EN && (time_left == '0);

`ifdef BATTLESHIP_HIT_BONUS_EN
    logic hit_q, hit_cap;
`else
    logic unused_hit;
    assign unused_hit = player_hit;
`endif

    always_comb begin
        state_d   = state_q;
        pc_go_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) state_d = PLACING;
            end
            PLACING: begin
                if (finished_placing) state_d = PLAYER_TURN;
            end
            PLAYER_TURN: begin
                // A fire edge in the expiry cycle wins over the timeout.
                if (fire_edge) begin
                    state_d = P_RESOLVE;
                end else if (expire) begin
                    state_d   = P_RESOLVE;
                    timeout_d = 1'b1;
                end
            end
            P_RESOLVE: begin
                if (pc_ships == '0) begin
                    state_d = VICTORY;
                end
`ifdef BATTLESHIP_HIT_BONUS_EN
                else if (hit_cap) begin
                    state_d = PLAYER_TURN;
                end
`endif
                else begin
                    state_d = PC_TURN;
                    pc_go_d = 1'b1;
                end
            end
            PC_TURN: begin
                if (pc_done) state_d = C_RESOLVE;
            end
            C_RESOLVE: begin
                state_d = (player_ships == '0) ? DEFEAT : PLAYER_TURN;
            end
            VICTORY, DEFEAT: begin
                if (start_edge) state_d = PLACING;
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_player = (state_q != PLAYER_TURN) && (state_d == PLAYER_TURN);
    assign leave_player = (state_q == PLAYER_TURN) && (state_d != PLAYER_TURN);
    assign restart      = ((state_q == VICTORY) || (state_q == DEFEAT)) && (state_d == PLACING);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            start_qq   <= 1'b0;
            fire_q     <= 1'b0;
            fire_qq    <= 1'b0;
            pc_go      <= 1'b0;
            timeout    <= 1'b0;
            time_left  <= '0;
            turn_count <= '0;
`ifdef BATTLESHIP_HIT_BONUS_EN
            hit_q      <= 1'b0;
            hit_cap    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            start_qq <= start_q;
            fire_q   <= player_fire;
            fire_qq  <= fire_q;
            pc_go    <= pc_go_d;
            timeout  <= timeout_d;
`ifdef BATTLESHIP_HIT_BONUS_EN
            hit_q    <= player_hit;
            if (leave_player) hit_cap <= fire_edge & hit_q;
`endif
            if (enter_player) begin
                time_left <= TIME_LOAD;
            end else if (restart) begin
                time_left <= '0;
            end else if ((state_q == PLAYER_TURN) && (time_left != '0)) begin
                time_left <= time_left - TIMER_W'(1);
            end

            if (restart) begin
                turn_count <= '0;
            end else if (leave_player && !(&turn_count)) begin
                turn_count <= turn_count + TURN_CNT_W'(1);
            end
        end
    end

    assign placing_ships = (state_q == PLACING);
    assign player_turn   = (state_q == PLAYER_TURN);
    assign pc_turn       = (state_q == PC_TURN);
    assign is_victory    = (state_q == VICTORY);
    assign is_defeat     = (state_q == DEFEAT);

endmodule
